matmul_tile_engine: RTL
=======================

MATMUL_TILE_ENGINE -- requirements
Module: matmul_tile_engine

Interface
REQ-001 Parameter M, default 4: rows of A and C.
REQ-002 Parameter K, default 4: columns of A and rows of B (the inner dimension).
REQ-003 Parameter N, default 4: columns of B and C.
REQ-004 Parameter DATA_W, default 32: width of each element.
REQ-005 Parameter ACC_W, default 2*DATA_W+8: accumulator width; shall be at least 2*DATA_W+clog2(K)+1.
REQ-006 Parameter LANES, default 4: number of parallel MAC lanes; 1 <= LANES <= M*N.
REQ-007 Clock and reset are decided: one clock; reset is asynchronous and active-high.
REQ-008 Port clk, input, 1: the single clock.
REQ-009 Port rst, input, 1: asynchronous active-high reset.
REQ-010 Port start, input, 1: request; sampled only in IDLE.
REQ-011 Port signed_mode, input, 1: 1 = two's-complement operands; 0 = unsigned operands.
REQ-012 Port accumulate, input, 1: 1 = C <= C + A*B; 0 = C <= A*B.
REQ-013 Port saturate, input, 1: 1 = clamp each result to the DATA_W range; 0 = truncate to the low DATA_W bits.
REQ-014 Port A, input, DATA_W x [M][K]: operand A, row-major; held stable while busy.
REQ-015 Port B, input, DATA_W x [K][N]: operand B, row-major; held stable while busy.
REQ-016 Port C, output, DATA_W x [M][N]: registered result matrix.
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port done, output, 1: one-cycle pulse when C is complete.

Function
REQ-019 States: IDLE, CALC, WRITE, DONE. Transitions:
- IDLE->CALC on start; the mode inputs are latched at the same edge.
- CALC->WRITE when k == K-1.
- WRITE->DONE when base+LANES >= M*N; otherwise WRITE->CALC.
- DONE->IDLE unconditionally.
REQ-020 Flattened output index: idx = base + lane, with row = idx / N and col = idx % N. base resets to 0 on leaving IDLE and advances by LANES on each WRITE.
REQ-021 CALC initialisation: on the CALC cycle with k == 0, each lane loads its accumulator before adding the first product.
- Accumulate mode: the sign- or zero-extended C[row][col].
- Otherwise: 0.
REQ-022 CALC step: each lane adds one product per cycle, A[row][k]*B[k][col], computed at 2*DATA_W, extended to ACC_W and interpreted per the latched signed_mode. k runs 0..K-1.
REQ-023 WRITE: each lane with idx < M*N writes its result to C[row][col]. Lanes with idx >= M*N write nothing and leave C unchanged.
REQ-024 Saturation: signed results clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; unsigned results clamp to [0, 2^DATA_W-1].
REQ-025 Latency: with P = ceil(M*N/LANES), done is high exactly P*(K+1)+1 cycles after the accepting edge.
REQ-026 start is ignored while busy, including during DONE. A start held high re-triggers from IDLE on the cycle after DONE.
REQ-027 Mode inputs changed mid-operation shall have no effect.

Reset
REQ-028 Reset forces: state IDLE, k 0, base 0, all accumulators 0, every C element 0, busy 0, done 0.
REQ-029 Reset asserted mid-operation aborts the operation with the same values; nothing is written afterwards.

Structure
REQ-030 Package matmul_pkg holds:
- the state enum mm_state_t;
- the function sat_trunc(value, signed_mode, saturate);
- a helper for the ACC_W lower bound.
REQ-031 Sub-module mac_lane (one instance per lane) contains the accumulator, its load/add control and the saturation/truncation output.
REQ-032 The engine holds the FSM, the k and base counters, the index decode and the C register array.

Verification
REQ-033 The bench shall cover these directed scenarios:
- 2x2x2, LANES=4, unsigned, A=[[1,2],[3,4]], B=identity -> C=[[1,2],[3,4]]; done at cycle 4; busy high 4 cycles.
- 3x3x3, LANES=4, A=B=all-ones -> all C=3; P=3; done at cycle 13; no write beyond index 8.
- Signed, DATA_W=8: A=[[-1]], B=[[5]] -> C=0xFB; same operands with signed_mode=0 -> C=0xFB (truncated 255*5=1275).
- DATA_W=8, saturate, unsigned, 1x2x1, A=[200,200], B=[1,1] -> C=255; signed A=[-100,-100], B=[1,1] -> C=-128.
- Accumulate, 2x2x2: C preloaded by a first run with A=B=identity (C=identity), then rerun -> C=2*identity.
- Reset asserted mid-CALC -> C all 0, IDLE, done never pulses; start pulsed while busy -> ignored, latency unchanged.

Source files
------------

// File: rtl/matmul_tile_engine_pkg.sv
// rtl/matmul_tile_engine_pkg.sv - shared state type and arithmetic helpers for the matmul tile engine
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WRITE,
        ST_DONE
    } mm_state_t;

    localparam int SAT_MAX_W = 128;

    function automatic int acc_w_min(input int data_w, input int k);
        return 2 * data_w + $clog2(k) + 1;
    endfunction

    // value arrives already sign/zero extended to SAT_MAX_W; the caller keeps the low data_w bits
    function automatic logic [SAT_MAX_W-1:0] sat_trunc(
        input logic [SAT_MAX_W-1:0] value,
        input int                   data_w,
        input logic                 signed_mode,
        input logic                 saturate
    );
        logic [SAT_MAX_W-1:0] hi;
        hi = '0;
        sat_trunc = value;
        if (saturate) begin
            if (signed_mode) begin
                hi = (SAT_MAX_W'(1) << (data_w - 1)) - SAT_MAX_W'(1);
                if ($signed(value) > $signed(hi)) begin
                    sat_trunc = hi;
                end else if ($signed(value) < $signed(~hi)) begin
                    sat_trunc = ~hi;
                end
            end else begin
                hi = (SAT_MAX_W'(1) << data_w) - SAT_MAX_W'(1);
                if (value > hi) begin
                    sat_trunc = hi;
                end
            end
        end
    endfunction

endpackage

// File: rtl/matmul_tile_engine_if.sv
// rtl/matmul_tile_engine_if.sv - request, operand and result bundle of the matmul tile engine
interface matmul_tile_engine_if #(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int DATA_W = 32
);
    logic              start;
    logic              signed_mode;
    logic              accumulate;
    logic              saturate;
    logic [DATA_W-1:0] A [M][K];
    logic [DATA_W-1:0] B [K][N];
    logic [DATA_W-1:0] C [M][N];
    logic              busy;
    logic              done;

    modport master (
        output start, signed_mode, accumulate, saturate, A, B,
        input  C, busy, done
    );

    modport slave (
        input  start, signed_mode, accumulate, saturate, A, B,
        output C, busy, done
    );
endinterface

// File: rtl/matmul_tile_engine_mac_lane.sv
// rtl/matmul_tile_engine_mac_lane.sv - one multiply-accumulate lane with saturating/truncating output
module mac_lane
    import matmul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 2 * DATA_W + 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_i,
    input  logic              load_i,
    input  logic              signed_mode_i,
    input  logic              accumulate_i,
    input  logic              saturate_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    output logic [DATA_W-1:0] result_o
);

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    seed, prod_x;
    logic [2*DATA_W-1:0] a_x, b_x, prod;

    // a 2*DATA_W product of extended operands is exact for both signed and unsigned inputs
    always_comb begin
        a_x    = {{DATA_W{signed_mode_i & a_i[DATA_W-1]}}, a_i};
        b_x    = {{DATA_W{signed_mode_i & b_i[DATA_W-1]}}, b_i};
        prod   = a_x * b_x;
        prod_x = {{(ACC_W - 2 * DATA_W){signed_mode_i & prod[2*DATA_W-1]}}, prod};
        seed   = accumulate_i ? {{(ACC_W - DATA_W){signed_mode_i & c_i[DATA_W-1]}}, c_i} : '0;
        acc_d  = acc_q;
        if (add_i) begin
            acc_d = (load_i ? seed : acc_q) + prod_x;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result_o = DATA_W'(sat_trunc(
        signed_mode_i ? SAT_MAX_W'($signed(acc_q)) : SAT_MAX_W'(acc_q),
        DATA_W, signed_mode_i, saturate_i));

endmodule

// File: rtl/matmul_tile_engine.sv
// rtl/matmul_tile_engine.sv - tiled C = A*B (+C) engine: FSM, k/base counters, index decode, C registers
module matmul_tile_engine
    import matmul_pkg::*;
#(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 2 * DATA_W + 8,
    parameter int LANES  = 4
) (
    input  logic           clk,
    input  logic           rst,
    matmul_tile_engine_if.slave bus
);

    localparam int MN = M * N;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(MN + LANES + 1);

    if (ACC_W < acc_w_min(DATA_W, K)) begin : g_acc_w_check
        $error("matmul_tile_engine: ACC_W too narrow for DATA_W and K");
    end
    if (LANES < 1 || LANES > MN) begin : g_lanes_check
        $error("matmul_tile_engine: LANES out of range");
    end

    mm_state_t         state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [BW-1:0]     base_q, base_d;
    logic              signed_q, accum_q, sat_q;
    logic              calc, load, write, busy, done;
    logic [DATA_W-1:0] c_q [M][N];

    logic [DATA_W-1:0] lane_res [LANES];
    logic [RW-1:0]     lane_row [LANES];
    logic [CW-1:0]     lane_col [LANES];
    logic              lane_ok  [LANES];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        calc    = 1'b0;
        load    = 1'b0;
        write   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_d = ST_CALC;
                    k_d     = '0;
                    base_d  = '0;
                end
            end
            ST_CALC: begin
                calc = 1'b1;
                load = (k_q == '0);
                if (k_q == KW'(K - 1)) begin
                    state_d = ST_WRITE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_WRITE: begin
                write  = 1'b1;
                base_d = base_q + BW'(LANES);
                if (32'(base_q) + 32'(LANES) >= 32'(MN)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            base_q   <= '0;
            signed_q <= 1'b0;
            accum_q  <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            if (state_q == ST_IDLE && bus.start) begin
                signed_q <= bus.signed_mode;
                accum_q  <= bus.accumulate;
                sat_q    <= bus.saturate;
            end
        end
    end

    // lanes past the last element of C decode to (0,0) but are never written
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] idx;
        assign idx         = 32'(base_q) + 32'(l);
        assign lane_ok[l]  = idx < 32'(MN);
        assign lane_row[l] = lane_ok[l] ? RW'(idx / 32'(N)) : '0;
        assign lane_col[l] = lane_ok[l] ? CW'(idx % 32'(N)) : '0;

        mac_lane #(
            .DATA_W(DATA_W),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk          (clk),
            .rst          (rst),
            .add_i        (calc),
            .load_i       (load),
            .signed_mode_i(signed_q),
            .accumulate_i (accum_q),
            .saturate_i   (sat_q),
            .a_i          (bus.A[lane_row[l]][k_q]),
            .b_i          (bus.B[k_q][lane_col[l]]),
            .c_i          (c_q[lane_row[l]][lane_col[l]]),
            .result_o     (lane_res[l])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    c_q[i][j] <= '0;
                end
            end
        end else if (write) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_ok[l]) begin
                    c_q[lane_row[l]][lane_col[l]] <= lane_res[l];
                end
            end
        end
    end

    assign bus.C    = c_q;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule
